// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the divider/multiplier output stages:
// class codes, exponent constants and the normalise-stage register bundle.
package fp32_pkg;

  typedef enum logic [1:0] {
    CLS_NORM = 2'b00,
    CLS_ZERO = 2'b01,
    CLS_INF  = 2'b10,
    CLS_NAN  = 2'b11
  } cls_e;

  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 2 * BIAS + 1;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  localparam int MANT_W = 24;
  // Internal exponent is kept wider than the input so that the -1 of
  // normalisation and the +1 of a rounding carry can never wrap.
  localparam int XW     = 16;

  typedef struct packed {
    logic                  valid;
    logic                  sign;
    cls_e                  cls;
    logic [MANT_W-1:0]     mant;
    logic                  g;
    logic                  s;
    logic signed [XW-1:0]  exp;
  } s1_t;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even on a 24-bit significand with guard/sticky bits;
// a carry out of the top bit is renormalised here.
module fp_rne_round
  import fp32_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic              g,
  input  logic              s,
  output logic [MANT_W-1:0] mant_r,
  output logic              carry,
  output logic              inexact
);

  logic            round_up;
  logic [MANT_W:0] sum;

  always_comb begin
    round_up = g & (s | mant[0]);
    sum      = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
    carry    = sum[MANT_W];
    mant_r   = carry ? sum[MANT_W:1] : sum[MANT_W-1:0];
    inexact  = g | s;
  end

endmodule

// File: rtl/fp_div_round_pack.sv
// Divider output stage: normalise, round-to-nearest-even, overflow/underflow
// detection and binary32 packing over two stall-able pipeline stages.
module fp_div_round_pack
  import fp32_pkg::*;
#(
  parameter int EXP_W = 10,
  parameter int QUO_W = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [QUO_W-1:0]        in_quo,
  input  logic                    in_rem_nz,
  input  logic [1:0]              in_cls,
  output logic                    out_valid,
  output logic [31:0]             C,
  output logic                    out_ovf,
  output logic                    out_unf,
  output logic                    out_inx
);

  s1_t s1_d, s1_q;

  logic signed [XW-1:0] exp_ext;

  always_comb begin
    s1_d       = '0;
    exp_ext    = XW'(in_exp);
    s1_d.valid = in_valid;
    s1_d.sign  = in_sign;
    s1_d.cls   = cls_e'(in_cls);
    if (in_quo[QUO_W-1]) begin
      s1_d.mant = in_quo[QUO_W-1 -: MANT_W];
      s1_d.g    = in_quo[1];
      s1_d.s    = in_quo[0] | in_rem_nz;
      s1_d.exp  = exp_ext;
    end else begin
      s1_d.mant = in_quo[QUO_W-2 -: MANT_W];
      s1_d.g    = in_quo[0];
      s1_d.s    = in_rem_nz;
      s1_d.exp  = exp_ext - XW'(1);
    end
  end

  logic [MANT_W-1:0] mant_r;
  logic              carry;
  logic              inexact_raw;

  fp_rne_round u_round (
    .mant    (s1_q.mant),
    .g       (s1_q.g),
    .s       (s1_q.s),
    .mant_r  (mant_r),
    .carry   (carry),
    .inexact (inexact_raw)
  );

  logic signed [XW-1:0] inc;
  logic signed [XW-1:0] exp2;
  logic [31:0]          c_d;
  logic                 ovf_d, unf_d, inx_d;

  always_comb begin
    c_d   = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = 1'b0;
    inc   = {{(XW-1){1'b0}}, carry};
    exp2  = s1_q.exp + inc;
    case (s1_q.cls)
      CLS_ZERO: c_d = {s1_q.sign, 31'h0};
      CLS_INF:  c_d = {s1_q.sign, 8'hFF, 23'h0};
      CLS_NAN:  c_d = QNAN;
      default: begin
        if (exp2 >= EXP_MAX) begin
          c_d   = {s1_q.sign, 8'hFF, 23'h0};
          ovf_d = 1'b1;
          inx_d = 1'b1;
        end else if (exp2 <= 0) begin
          // No subnormal output: anything below the normal range flushes.
          c_d   = {s1_q.sign, 31'h0};
          unf_d = 1'b1;
          inx_d = 1'b1;
        end else begin
          c_d   = {s1_q.sign, exp2[7:0], mant_r[22:0]};
          inx_d = inexact_raw;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q      <= '0;
      out_valid <= 1'b0;
      C         <= '0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
      out_inx   <= 1'b0;
    end else if (en) begin
      s1_q      <= s1_d;
      out_valid <= s1_q.valid;
      if (s1_q.valid) begin
        C       <= c_d;
        out_ovf <= ovf_d;
        out_unf <= unf_d;
        out_inx <= inx_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_div_round_pack.sv
// Scoreboard bench for fp_div_round_pack: a value-level rounding model
// predicts each result when the DUT accepts it; a monitor checks outputs.
module tb_fp_div_round_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [25:0] in_quo = '0;
  logic        in_rem_nz = 1'b0;
  logic [1:0]  in_cls = '0;
  logic        out_valid;
  logic [31:0] C;
  logic        out_ovf, out_unf, out_inx;

  fp_div_round_pack #(.EXP_W(10), .QUO_W(26)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_sign(in_sign),
    .in_exp(in_exp), .in_quo(in_quo), .in_rem_nz(in_rem_nz), .in_cls(in_cls),
    .out_valid(out_valid), .C(C), .out_ovf(out_ovf), .out_unf(out_unf),
    .out_inx(out_inx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c;
    logic        ovf, unf, inx;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ecyc = 0;
  bit   last_en = 0;
  bit   last_rst = 0;

  // Exact value is qv * 2^(e-127-25); keep the top 24 significant bits and
  // round the discarded part (plus remainder sticky) against one half ulp.
  function automatic exp_t model(logic sg, int e, logic [25:0] qv, logic rnz,
                                 logic [1:0] cls);
    exp_t   r;
    longint m, rem, half;
    int     msb, k, ea;
    bit     up;
    r.c = '0; r.ovf = 0; r.unf = 0; r.inx = 0; r.due = 0;
    case (cls)
      2'b01: r.c = {sg, 31'h0};
      2'b10: r.c = {sg, 8'hFF, 23'h0};
      2'b11: r.c = 32'h7FC0_0000;
      default: begin
        msb = 0;
        for (int i = 0; i < 26; i++) if (qv[i]) msb = i;
        k    = msb - 23;
        ea   = e + msb - 25;
        m    = longint'(qv) >> k;
        rem  = longint'(qv) & ((64'sd1 << k) - 1);
        half = 64'sd1 << (k - 1);
        up   = (rem > half) || (rem == half && (rnz || m[0]));
        r.inx = (rem != 0) || rnz;
        if (up) m = m + 1;
        if (m == (64'sd1 << 24)) begin
          m  = m >> 1;
          ea = ea + 1;
        end
        if (ea >= 255) begin
          r.c = {sg, 8'hFF, 23'h0}; r.ovf = 1; r.inx = 1;
        end else if (ea <= 0) begin
          r.c = {sg, 31'h0}; r.unf = 1; r.inx = 1;
        end else begin
          r.c = {sg, ea[7:0], m[22:0]};
        end
      end
    endcase
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Acceptance tracker: predicts a result whenever the DUT samples an input.
  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      last_rst = 1;
      last_en  = 0;
    end else begin
      last_rst = 0;
      last_en  = en;
      if (en) begin
        if (in_valid) begin
          exp_t e;
          e = model(in_sign, int'($signed(in_exp)), in_quo, in_rem_nz, in_cls);
          e.due = ecyc + 1;
          q.push_back(e);
        end
        ecyc++;
      end
    end
  end

  always @(negedge clk) begin
    if (last_rst) begin
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_C", C, 32'd0);
      chk("reset_flags", {29'd0, out_ovf, out_unf, out_inx}, 32'd0);
    end else if (last_en) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got C=%h, expected no result", C);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latency", 32'(ecyc - 1), 32'(e.due));
          chk("C", C, e.c);
          chk("flags", {29'd0, out_ovf, out_unf, out_inx},
              {29'd0, e.ovf, e.unf, e.inx});
        end
      end else if (q.size() > 0 && q[0].due <= ecyc - 1) begin
        checks++; errors++;
        $display("FAIL missing_output: got out_valid=0, expected C=%h", q[0].c);
        void'(q.pop_front());
      end
    end
  end

  task automatic drive(bit v, bit sg, int e, logic [25:0] qv, bit rnz,
                       logic [1:0] cls);
    @(negedge clk);
    in_valid  = v;
    in_sign   = sg;
    in_exp    = 10'(e);
    in_quo    = qv;
    in_rem_nz = rnz;
    in_cls    = cls;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 26'h2000000, 0, 2'b00);
  endtask

  task automatic rand_in(bit v);
    logic [25:0] qv;
    logic [1:0]  cls;
    qv  = 26'($urandom_range(32'h3FFFFFF, 32'h1000001));
    cls = ($urandom_range(7, 0) == 0) ? 2'($urandom) : 2'b00;
    drive(v, 1'($urandom), int'($urandom_range(600, 0)) - 300, qv,
          1'($urandom), cls);
  endtask

  initial begin
    rst = 0; en = 1;
    idle(3);
    rst = 1;
    idle(2);

    drive(1, 0, 128, 26'h2000000, 0, 2'b00);   // 2/1 exact
    idle(2);
    drive(1, 0, 127, 26'h1800000, 0, 2'b00);   // 0.75
    drive(1, 0, 130, 26'h3000000, 0, 2'b00);   // 12
    drive(1, 0, 127, 26'h2000006, 0, 2'b00);   // tie rounds up to even
    drive(1, 0, 127, 26'h2000002, 0, 2'b00);   // tie stays even
    drive(1, 0, 254, 26'h3FFFFFE, 1, 2'b00);   // carry into overflow
    drive(1, 1, 0,   26'h2000000, 0, 2'b00);   // underflow flush
    drive(1, 0, 253, 26'h3FFFFFF, 0, 2'b00);   // carry to exp 254, no ovf
    drive(1, 0, 1,   26'h1FFFFFF, 1, 2'b00);   // normalise into exp 0
    drive(1, 0, 100, 26'h2000000, 0, 2'b11);   // NaN
    drive(1, 1, 100, 26'h2000000, 0, 2'b10);   // -inf
    drive(1, 0, 100, 26'h2000000, 1, 2'b01);   // zero
    idle(3);

    for (int i = 0; i < 4; i++) rand_in(1);     // back-to-back, then stall
    en = 0;
    for (int i = 0; i < 3; i++) rand_in(1);
    en = 1;
    for (int i = 0; i < 2; i++) rand_in(1);
    idle(3);

    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(7, 0) != 0);
      rand_in($urandom_range(3, 0) != 0);
    end
    en = 1;
    idle(3);

    rand_in(1);
    rand_in(1);
    rst = 0;                                    // discard in-flight results
    idle(2);
    rst = 1;
    idle(4);
    for (int i = 0; i < 5; i++) rand_in(1);
    idle(4);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
